// File: rtl/sort_pkg.sv
// Shared definitions for the rank-based sorter family.
//   state_e     : sequencing states of the streaming sorter (load, rank, emit).
//   KeyMaxW     : widest key the precedence helper accepts; callers zero-extend.
//   rank_before : 1 when key a (at index ia) sorts ahead of key b (at index ib).
package sort_pkg;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StRank = 2'd1,
    StEmit = 2'd2
  } state_e;

  localparam int unsigned KeyMaxW = 64;

  // Ties are broken by arrival index in both orders, which keeps ranks unique and the sort stable.
  function automatic logic rank_before(input logic [KeyMaxW-1:0] a,
                                       input logic [KeyMaxW-1:0] b,
                                       input logic [31:0]        ia,
                                       input logic [31:0]        ib,
                                       input logic               desc);
    if (a == b) return (ia < ib);
    return desc ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/rank_count.sv
// Combinational rank of one buffered key within a frame of N keys.
//   keys_i : all N buffered keys, index 0 arrived first
//   idx_i  : index of the key being ranked
//   desc_i : 0 ascending, 1 descending
//   rank_o : number of keys that sort ahead of keys_i[idx_i] (0..N-1)
// Kept as its own block so the compare/popcount tree can be pipelined later.
module rank_count import sort_pkg::*; #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(N)
) (
  input  logic [N-1:0][WIDTH-1:0] keys_i,
  input  logic [CW-1:0]           idx_i,
  input  logic                    desc_i,
  output logic [CW-1:0]           rank_o
);

  logic [KeyMaxW-1:0] self_key;

  assign self_key = KeyMaxW'(keys_i[idx_i]);

  always_comb begin
    rank_o = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if ((j != 32'(idx_i)) &&
          rank_before(KeyMaxW'(keys_i[j[CW-1:0]]), self_key, j, 32'(idx_i), desc_i)) begin
        rank_o = rank_o + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stream_rank_sorter.sv
// Streaming frame sorter: loads N keys over valid/ready, ranks one key per cycle into a
// sorted buffer, then streams the sorted frame out with backpressure. Frames do not overlap.
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset; aborts any frame in progress
//   desc_i       : order select (0 ascending, 1 descending), taken with the first key of a frame
//   in_valid_i   : input key valid
//   in_ready_o   : sorter accepts a key (LOAD only)
//   in_data_i    : input key
//   out_valid_o  : sorted key valid
//   out_ready_i  : downstream accepts the key
//   out_data_o   : sorted key
//   out_last_o   : marks the final key of a frame
//   busy_o       : high while ranking or emitting
module stream_rank_sorter import sort_pkg::*; #(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             desc_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  output logic             busy_o
);

  localparam int unsigned   CW      = $clog2(N);
  localparam logic [CW-1:0] LastIdx = CW'(N - 1);

  state_e                  state_q;
  logic [CW-1:0]           load_cnt_q;
  logic [CW-1:0]           rank_cnt_q;
  logic [CW-1:0]           emit_cnt_q;
  logic                    mode_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [WIDTH-1:0]        out_data_q;
  logic                    busy_q;

  logic [N-1:0][WIDTH-1:0] key_q;
  logic [WIDTH-1:0]        sorted_q [N];

  logic                    load_fire;
  logic [CW-1:0]           rank_idx;
  logic [CW-1:0]           emit_nxt;

  // in_ready_q is only ever high in StLoad, so this also qualifies the state.
  assign load_fire = in_valid_i && in_ready_q;
  assign emit_nxt  = emit_cnt_q + CW'(1);

  rank_count #(
    .N     (N),
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_rank_count (
    .keys_i (key_q),
    .idx_i  (rank_cnt_q),
    .desc_i (mode_q),
    .rank_o (rank_idx)
  );

  // Key storage is not reset; every location is rewritten before it is read in a frame.
  always_ff @(posedge clk_i) begin
    if (load_fire) begin
      key_q[load_cnt_q] <= in_data_i;
    end
    if (state_q == StRank) begin
      sorted_q[rank_idx] <= key_q[rank_cnt_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StLoad;
      load_cnt_q  <= '0;
      rank_cnt_q  <= '0;
      emit_cnt_q  <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (load_fire) begin
            if (load_cnt_q == '0) begin
              mode_q <= desc_i;
            end
            if (load_cnt_q == LastIdx) begin
              load_cnt_q <= '0;
              rank_cnt_q <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= StRank;
            end else begin
              load_cnt_q <= load_cnt_q + CW'(1);
            end
          end
        end
        StRank: begin
          if (rank_cnt_q == LastIdx) begin
            rank_cnt_q  <= '0;
            emit_cnt_q  <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            // The final key may land in slot 0 on this very edge, so bypass the buffer.
            out_data_q  <= (rank_idx == '0) ? key_q[rank_cnt_q] : sorted_q[0];
            state_q     <= StEmit;
          end else begin
            rank_cnt_q <= rank_cnt_q + CW'(1);
          end
        end
        StEmit: begin
          if (out_ready_i) begin
            if (emit_cnt_q == LastIdx) begin
              emit_cnt_q  <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= StLoad;
            end else begin
              emit_cnt_q <= emit_nxt;
              out_data_q <= sorted_q[emit_nxt];
              out_last_q <= (emit_nxt == LastIdx);
            end
          end
        end
        default: begin
          state_q <= StLoad;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_stream_rank_sorter.sv
// Scoreboard bench for stream_rank_sorter: an N=8/WIDTH=8 instance and an N=5/WIDTH=16 instance.
module tb_stream_rank_sorter;

  typedef logic [15:0] key_arr_t [8];
  typedef logic [7:0]  idx_arr_t [8];
  typedef struct packed {
    logic [15:0] key;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  localparam int NA = 8;
  localparam int NB = 5;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  logic       a_desc, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [7:0] a_in_data, a_out_data;
  logic        b_desc, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [15:0] b_in_data, b_out_data;

  exp_t a_q[$];
  exp_t b_q[$];
  bit   a_bp;
  bit   a_lat_pend;
  int   a_last_in_cyc;

  stream_rank_sorter #(.N(NA), .WIDTH(8)) u_dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .desc_i      (a_desc),
    .in_valid_i  (a_in_valid),
    .in_ready_o  (a_in_ready),
    .in_data_i   (a_in_data),
    .out_valid_o (a_out_valid),
    .out_ready_i (a_out_ready),
    .out_data_o  (a_out_data),
    .out_last_o  (a_out_last),
    .busy_o      (a_busy)
  );

  stream_rank_sorter #(.N(NB), .WIDTH(16)) u_dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .desc_i      (b_desc),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .in_data_i   (b_in_data),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .out_data_o  (b_out_data),
    .out_last_o  (b_out_last),
    .busy_o      (b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got nothing or extra, expected a matching event", name);
  endtask

  task automatic push(input bit to_b, input key_arr_t k, input idx_arr_t x, input int cnt,
                      input int n);
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      e.key  = k[i];
      e.idx  = x[i];
      e.last = (i == n - 1);
      if (to_b) b_q.push_back(e);
      else      a_q.push_back(e);
    end
  endtask

  task automatic send_a(input key_arr_t k, input logic d, input bit tog, input bit gaps);
    for (int i = 0; i < NA; i++) begin
      int n;
      bit acc;
      a_in_data  = k[i][7:0];
      a_desc     = (tog && i[0]) ? ~d : d;
      a_in_valid = 1'b1;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = a_in_ready;
        @(posedge clk);
        n++;
      end
      #1;
      a_in_valid = 1'b0;
      if (!acc) bad($sformatf("a_in_accept beat %0d", i));
      if (i == NA - 1) begin
        a_last_in_cyc = cyc;
        a_lat_pend    = 1'b1;
      end
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_b(input key_arr_t k, input logic d);
    for (int i = 0; i < NB; i++) begin
      int n;
      bit acc;
      b_in_data  = k[i];
      b_desc     = d;
      b_in_valid = 1'b1;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = b_in_ready;
        @(posedge clk);
        n++;
      end
      #1;
      b_in_valid = 1'b0;
      if (!acc) bad($sformatf("b_in_accept beat %0d", i));
    end
  endtask

  // Backpressure on the N=8 output: always ready, or roughly 30% duty when a_bp is set.
  initial begin
    a_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a_out_ready = a_bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor for the N=8 instance.
  bit         a_stall;
  logic [7:0] a_hold_data;
  logic       a_hold_last;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      a_stall = 1'b0;
    end else begin
      if (a_busy) check("a_in_ready_while_busy", 32'(a_in_ready), 32'd0);
      if (a_stall) begin
        check("a_hold_valid", 32'(a_out_valid), 32'd1);
        check("a_hold_data", 32'(a_out_data), 32'(a_hold_data));
        check("a_hold_last", 32'(a_out_last), 32'(a_hold_last));
      end
      if (a_lat_pend && a_out_valid) begin
        check("a_latency", 32'(cyc + 1 - a_last_in_cyc), 32'(NA + 1));
        a_lat_pend = 1'b0;
      end
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          bad("a_unexpected_output");
        end else begin
          e = a_q.pop_front();
          check($sformatf("a_data(in idx %0d)", e.idx), 32'(a_out_data), 32'(e.key));
          check($sformatf("a_last(in idx %0d)", e.idx), 32'(a_out_last), 32'(e.last));
        end
      end
      a_stall     = a_out_valid && !a_out_ready;
      a_hold_data = a_out_data;
      a_hold_last = a_out_last;
    end
  end

  // Monitor for the N=5 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b_busy) check("b_in_ready_while_busy", 32'(b_in_ready), 32'd0);
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) begin
          bad("b_unexpected_output");
        end else begin
          e = b_q.pop_front();
          check($sformatf("b_data(in idx %0d)", e.idx), 32'(b_out_data), 32'(e.key));
          check($sformatf("b_last(in idx %0d)", e.idx), 32'(b_out_last), 32'(e.last));
        end
      end
    end
  end

  key_arr_t k_mix, k_dup, k_same, k_b;
  key_arr_t e_asc, e_desc, e_dup_asc, e_dup_desc, e_same, e_b_asc, e_b_desc;
  idx_arr_t x_asc, x_desc, x_dup_asc, x_dup_desc, x_same, x_b_asc, x_b_desc;

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    a_bp = 1'b0;
    a_lat_pend = 1'b0;
    a_last_in_cyc = 0;
    rst_n = 1'b0;
    a_desc = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
    b_desc = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

    k_mix  = '{5, 3, 9, 1, 7, 2, 8, 4};
    e_asc  = '{1, 2, 3, 4, 5, 7, 8, 9};       x_asc  = '{3, 5, 1, 7, 0, 4, 6, 2};
    e_desc = '{9, 8, 7, 5, 4, 3, 2, 1};       x_desc = '{2, 6, 4, 0, 7, 1, 5, 3};
    k_dup      = '{4, 4, 2, 4, 2, 0, 0, 255};
    e_dup_asc  = '{0, 0, 2, 2, 4, 4, 4, 255}; x_dup_asc  = '{5, 6, 2, 4, 0, 1, 3, 7};
    e_dup_desc = '{255, 4, 4, 4, 2, 2, 0, 0}; x_dup_desc = '{7, 0, 1, 3, 2, 4, 5, 6};
    k_same = '{7, 7, 7, 7, 7, 7, 7, 7};
    e_same = '{7, 7, 7, 7, 7, 7, 7, 7};       x_same = '{0, 1, 2, 3, 4, 5, 6, 7};
    k_b      = '{65535, 0, 32768, 1, 65534, 0, 0, 0};
    e_b_asc  = '{0, 1, 32768, 65534, 65535, 0, 0, 0}; x_b_asc  = '{1, 3, 2, 4, 0, 0, 0, 0};
    e_b_desc = '{65535, 65534, 32768, 1, 0, 0, 0, 0}; x_b_desc = '{0, 4, 2, 3, 1, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("a_rst_in_ready", 32'(a_in_ready), 32'd1);
    check("a_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("a_rst_out_last", 32'(a_out_last), 32'd0);
    check("a_rst_busy", 32'(a_busy), 32'd0);
    check("a_rst_out_data", 32'(a_out_data), 32'd0);
    check("b_rst_in_ready", 32'(b_in_ready), 32'd1);
    check("b_rst_out_valid", 32'(b_out_valid), 32'd0);
    check("b_rst_busy", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-rate frames: ascending, descending with desc toggling mid-load, duplicates, all equal.
    push(1'b0, e_asc, x_asc, NA, NA);           send_a(k_mix, 1'b0, 1'b0, 1'b0);
    push(1'b0, e_desc, x_desc, NA, NA);         send_a(k_mix, 1'b1, 1'b1, 1'b0);
    push(1'b0, e_dup_asc, x_dup_asc, NA, NA);   send_a(k_dup, 1'b0, 1'b0, 1'b0);
    push(1'b0, e_same, x_same, NA, NA);         send_a(k_same, 1'b1, 1'b0, 1'b0);

    // Output backpressure plus input gaps.
    a_bp = 1'b1;
    push(1'b0, e_asc, x_asc, NA, NA);           send_a(k_mix, 1'b0, 1'b0, 1'b1);
    push(1'b0, e_dup_desc, x_dup_desc, NA, NA); send_a(k_dup, 1'b1, 1'b1, 1'b1);
    a_bp = 1'b0;

    // Reset during RANK cycle 3: the frame never produces output.
    send_a(k_mix, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_lat_pend = 1'b0;
    #1;
    check("a_rank_abort_out_valid", 32'(a_out_valid), 32'd0);
    check("a_rank_abort_busy", 32'(a_busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("a_rank_abort_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset during EMIT after two keys have been taken.
    push(1'b0, e_asc, x_asc, 2, NA);
    send_a(k_mix, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (a_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (a_q.size() != 0) bad("a_emit_two_before_reset");
    #1;
    rst_n = 1'b0;
    #1;
    check("a_emit_abort_out_valid", 32'(a_out_valid), 32'd0);
    check("a_emit_abort_out_last", 32'(a_out_last), 32'd0);
    check("a_emit_abort_busy", 32'(a_busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("a_emit_abort_in_ready", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Clean frame after the aborts.
    push(1'b0, e_desc, x_desc, NA, NA);         send_a(k_mix, 1'b1, 1'b1, 1'b1);

    // Non-power-of-two instance: two back-to-back frames exercise the counter clears.
    push(1'b1, e_b_asc, x_b_asc, NB, NB);       send_b(k_b, 1'b0);
    push(1'b1, e_b_desc, x_b_desc, NB, NB);     send_b(k_b, 1'b1);

    n = 0;
    while ((a_q.size() != 0 || b_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (a_q.size() != 0) bad($sformatf("a_drain (%0d keys left)", a_q.size()));
    if (b_q.size() != 0) bad($sformatf("b_drain (%0d keys left)", b_q.size()));
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_rank_sorter.md
Name: stream_rank_sorter

Overview:
- Sequential, parametrised successor to the team's combinational comparison-count sorter.
- Accepts a frame of exactly N keys over a valid/ready stream and buffers them.
- Computes a unique, stable rank per key, one key per cycle, then streams the sorted frame out with backpressure.
- Supports ascending or descending order per frame. Sits between a sample-capture front end and downstream statistics (median/percentile) logic.

Parameters:
- N, 8, keys per frame; N >= 2.
- WIDTH, 8, key width in bits (unsigned compare).
- CW, $clog2(N), derived, index/rank width; not user-overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- desc  in  1  order select: 0 ascending, 1 descending; sampled with the first accepted key of a frame.
- in_valid  in  1  input key valid.
- in_ready  out  1  sorter can accept a key.
- in_data  in  WIDTH  input key.
- out_valid  out  1  sorted key valid.
- out_ready  in  1  downstream accepts the key.
- out_data  out  WIDTH  sorted key.
- out_last  out  1  high with the N-th (final) output key of a frame.
- busy  out  1  high in RANK or EMIT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=LOAD; load, rank and emit counters=0.
  - in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
  - Key buffers need not be cleared.
- LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready cycle writes in_data to buf[load_cnt] and increments load_cnt.
  - On the first beat (load_cnt==0), register desc into mode_q.
  - On the beat with load_cnt==N-1: load_cnt->0, go to RANK next cycle.
  - in_valid low stalls without penalty.
- RANK (exactly N cycles, rank_cnt i=0..N-1):
  - in_ready=0, busy=1.
  - Ascending: rank = count of j!=i with buf[j]<buf[i], or buf[j]==buf[i] and j<i.
  - Descending: same rule with > replacing <.
  - This gives stable, collision-free ranks in 0..N-1. No overwrite handling and no clamping is needed.
  - In the same cycle, write sorted[rank]=buf[i].
  - The N-way compare-and-popcount is combinational; ranks are registered only through the sorted[] write.
  - After i==N-1, go to EMIT.
- EMIT:
  - out_valid=1, out_data=sorted[emit_cnt], out_last=(emit_cnt==N-1), busy=1.
  - On out_valid&&out_ready, increment emit_cnt.
  - The handshake with out_last: emit_cnt->0, return to LOAD. in_ready=1 on the following cycle.
  - out_data and out_last are held stable while out_valid&&!out_ready.
- Latency:
  - Last input beat accepted at edge t; first out_valid at cycle t+N+1.
  - Minimum frame period is 2N+N cycles (load N, rank N, emit N) with no stalls.
  - No overlap between frames.
- desc changes outside the first load beat are ignored for the current frame.
- Reset mid-frame (any state) aborts the frame. Outputs return to reset values; no partial output is ever completed.
- Equal keys appear in arrival order in both modes.
- Counters wrap only by explicit clear at N-1. They never run past N-1, including for non-power-of-two N.

Decomposition:
- Shared package sort_pkg:
  - state enum typedef {LOAD, RANK, EMIT}.
  - Function rank_before(a, b, ia, ib, desc) returning the stable precedence bit; reused by the combinational sorter family.
- One sub-module: rank_count (combinational, N keys + index + mode in, CW-bit rank out). It isolates the compare/popcount tree so it can be pipelined later.

Test Plan:
- Ascending, N=8, desc=0, keys 5,3,9,1,7,2,8,4 at full rate, out_ready=1 → out 1,2,3,4,5,7,8,9. out_last on 9; first out_valid 9 cycles after the last input.
- Descending, same keys, desc=1 on the first beat → out 9,8,7,5,4,3,2,1. Toggling desc mid-load has no effect.
- Duplicates/stability, keys 4,4,2,4,2,0,0,255 ascending → 0,0,2,2,4,4,4,255. Bench tags the input index in the scoreboard and checks equal keys exit in input order. All-equal frame 7×8 → eight 7s.
- Backpressure: out_ready random 30% duty plus in_valid gaps → identical sorted sequence. out_data/out_last stable while stalled; in_ready=0 throughout RANK/EMIT.
- Reset mid-operation: assert rst_n=0 during RANK cycle 3, then during EMIT after 2 outputs → immediately out_valid=0, busy=0, in_ready=1 after release. The next full frame sorts correctly.
- Parameter sweep N=5, WIDTH=16, keys 65535,0,32768,1,65534 ascending → 0,1,32768,65534,65535. Counters clear at 4; no out-of-range index.
